fp_align_stage: RTL and testbench

FP_ALIGN_STAGE -- requirements
Module: fp_align_stage

---
 rtl/fp_align_stage.sv | 134 +++++++++++++
 tb/tb_fp_align_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_align_stage.sv
// rtl/fp_align_stage.sv - binary32 operand alignment stage for a floating-point adder
// Two-register pipeline: S1 decodes and orders the operands, S2 shifts the smaller mantissa.
module fp_align_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign_big,
  output logic        sign_small,
  output logic [7:0]  exp_big,
  output logic [23:0] mant_big,
  output logic [26:0] mant_small_sh,
  output logic        swapped,
  output logic        eff_sub
);

  logic        r_s1_valid;
  logic        r_s1_sign_big;
  logic        r_s1_sign_small;
  logic [7:0]  r_s1_exp_big;
  logic [23:0] r_s1_mant_big;
  logic [23:0] r_s1_mant_small;
  logic [7:0]  r_s1_dist;
  logic        r_s1_swapped;

  logic        r_s2_valid;
  logic        r_sign_big;
  logic        r_sign_small;
  logic [7:0]  r_exp_big;
  logic [23:0] r_mant_big;
  logic [26:0] r_mant_small_sh;
  logic        r_swapped;
  logic        r_eff_sub;

  logic        w_s2_load;
  logic        w_s1_advance;
  logic        w_accept;
  logic [7:0]  w_exp_a;
  logic [7:0]  w_exp_b;
  logic [23:0] w_mant_a;
  logic [23:0] w_mant_b;
  logic        w_a_big;
  logic [26:0] w_ext;
  logic [26:0] w_shifted;
  logic [26:0] w_lost_mask;
  logic        w_sticky;
  logic        w_near;
  logic [26:0] w_mant_small_sh;

  assign w_s2_load    = !r_s2_valid || out_ready;
  assign w_s1_advance = r_s1_valid && w_s2_load;
  assign w_accept     = in_valid && in_ready;
  assign in_ready     = !r_s1_valid || w_s1_advance;

  // Exponent field 0 is a denormal/zero: no hidden bit, effective exponent 1.
  assign w_exp_a  = (A[30:23] == 8'd0) ? 8'd1 : A[30:23];
  assign w_exp_b  = (B[30:23] == 8'd0) ? 8'd1 : B[30:23];
  assign w_mant_a = {|A[30:23], A[22:0]};
  assign w_mant_b = {|B[30:23], B[22:0]};
  assign w_a_big  = {w_exp_a, w_mant_a} >= {w_exp_b, w_mant_b};

  assign w_ext           = {r_s1_mant_small, 3'b000};
  assign w_near          = r_s1_dist < 8'd27;
  assign w_shifted       = w_ext >> r_s1_dist[4:0];
  assign w_lost_mask     = ~({27{1'b1}} << r_s1_dist[4:0]);
  assign w_sticky        = |(w_ext & w_lost_mask);
  assign w_mant_small_sh = w_near ? {w_shifted[26:1], w_shifted[0] | w_sticky}
                                  : {26'd0, |r_s1_mant_small};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid      <= 1'b0;
      r_s1_sign_big   <= 1'b0;
      r_s1_sign_small <= 1'b0;
      r_s1_exp_big    <= 8'd0;
      r_s1_mant_big   <= 24'd0;
      r_s1_mant_small <= 24'd0;
      r_s1_dist       <= 8'd0;
      r_s1_swapped    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s1_valid      <= 1'b1;
        r_s1_swapped    <= !w_a_big;
        r_s1_sign_big   <= w_a_big ? A[31] : B[31];
        r_s1_sign_small <= w_a_big ? B[31] : A[31];
        r_s1_exp_big    <= w_a_big ? w_exp_a : w_exp_b;
        r_s1_mant_big   <= w_a_big ? w_mant_a : w_mant_b;
        r_s1_mant_small <= w_a_big ? w_mant_b : w_mant_a;
        r_s1_dist       <= w_a_big ? (w_exp_a - w_exp_b) : (w_exp_b - w_exp_a);
      end else if (w_s1_advance) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid      <= 1'b0;
      r_sign_big      <= 1'b0;
      r_sign_small    <= 1'b0;
      r_exp_big       <= 8'd0;
      r_mant_big      <= 24'd0;
      r_mant_small_sh <= 27'd0;
      r_swapped       <= 1'b0;
      r_eff_sub       <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      // Data only moves with a valid pair so an idle S2 keeps its last result.
      if (r_s1_valid) begin
        r_sign_big      <= r_s1_sign_big;
        r_sign_small    <= r_s1_sign_small;
        r_exp_big       <= r_s1_exp_big;
        r_mant_big      <= r_s1_mant_big;
        r_mant_small_sh <= w_mant_small_sh;
        r_swapped       <= r_s1_swapped;
        r_eff_sub       <= r_s1_sign_big ^ r_s1_sign_small;
      end
    end
  end

  assign out_valid     = r_s2_valid;
  assign sign_big      = r_sign_big;
  assign sign_small    = r_sign_small;
  assign exp_big       = r_exp_big;
  assign mant_big      = r_mant_big;
  assign mant_small_sh = r_mant_small_sh;
  assign swapped       = r_swapped;
  assign eff_sub       = r_eff_sub;

endmodule

// File: tb/tb_fp_align_stage.sv
// tb/tb_fp_align_stage.sv - self-checking bench for fp_align_stage
// Directed vectors, backpressure and reset sequences, then randomized traffic against a scoreboard.
module tb_fp_align_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic        sign_big;
  logic        sign_small;
  logic [7:0]  exp_big;
  logic [23:0] mant_big;
  logic [26:0] mant_small_sh;
  logic        swapped;
  logic        eff_sub;
  logic [62:0] dut_pack;

  int n_total = 0;
  int n_pass  = 0;

  fp_align_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready),
    .sign_big(sign_big), .sign_small(sign_small), .exp_big(exp_big),
    .mant_big(mant_big), .mant_small_sh(mant_small_sh),
    .swapped(swapped), .eff_sub(eff_sub)
  );

  assign dut_pack = {sign_big, sign_small, exp_big, mant_big, mant_small_sh, swapped, eff_sub};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sb;
    logic        ss;
    logic [7:0]  e;
    logic [23:0] mb;
    logic [26:0] msh;
    logic        sw;
    logic        es;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, expv);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  // Reference: order by magnitude, then divide by 2^d and note any remainder as sticky.
  function automatic logic [62:0] model(input logic [31:0] x, input logic [31:0] y);
    longint ex, ey, mx, my, eb, es, mb, ms, d, ext, q;
    logic sb, ss, sw;
    logic [26:0] sh;
    ex = (x[30:23] == 0) ? 1 : longint'(x[30:23]);
    ey = (y[30:23] == 0) ? 1 : longint'(y[30:23]);
    mx = longint'(x[22:0]) + ((x[30:23] != 0) ? 64'd8388608 : 64'd0);
    my = longint'(y[22:0]) + ((y[30:23] != 0) ? 64'd8388608 : 64'd0);
    sw = !((ex > ey) || (ex == ey && mx >= my));
    eb = sw ? ey : ex;  es = sw ? ex : ey;
    mb = sw ? my : mx;  ms = sw ? mx : my;
    sb = sw ? y[31] : x[31];
    ss = sw ? x[31] : y[31];
    d = eb - es;
    ext = ms * 8;
    if (d >= 27) sh = (ext != 0) ? 27'd1 : 27'd0;
    else begin
      q = ext / (64'd1 << d);
      sh = 27'(q) | ((q * (64'd1 << d) != ext) ? 27'd1 : 27'd0);
    end
    return {sb, ss, 8'(eb), 24'(mb), sh, sw, sb ^ ss};
  endfunction

  task automatic gen_pair(output logic [31:0] x, output logic [31:0] y);
    x = $urandom;
    y = $urandom;
    case ($urandom_range(0, 3))
      1: y = {1'($urandom), x[30:23], 23'($urandom)};
      2: y[30:23] = x[30:23] + 8'($urandom_range(0, 30));
      3: begin
        x[30:23] = 8'd0;
        if ($urandom_range(0, 1) == 1) y[30:0] = 31'd0;
      end
      default: ;
    endcase
  endtask

  logic [62:0] q[$];
  logic [62:0] prev;
  logic        hold_prev;
  logic [31:0] pa[3];
  logic [31:0] pb[3];
  int          seen;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vt[0] = '{32'h3F800000, 32'h40000000, 0, 0, 8'h80, 24'h800000, 27'h2000000, 1, 0};
    vt[1] = '{32'h3F800001, 32'h3F800000, 0, 0, 8'h7F, 24'h800001, 27'h4000000, 0, 0};
    vt[2] = '{32'h4B800000, 32'h3F800001, 0, 0, 8'h97, 24'h800000, 27'h0000005, 0, 0};
    vt[3] = '{32'h7F000000, 32'h3F800000, 0, 0, 8'hFE, 24'h800000, 27'h0000001, 0, 0};
    vt[4] = '{32'h00000001, 32'h80000000, 0, 1, 8'h01, 24'h000001, 27'h0000000, 0, 1};
    vt[5] = '{32'hC0000000, 32'h40400000, 0, 1, 8'h80, 24'hC00000, 27'h4000000, 1, 1};
    vt[6] = '{32'h41200000, 32'h41200000, 0, 0, 8'h82, 24'hA00000, 27'h5000000, 0, 0};
    vt[7] = '{32'h4C000000, 32'h3F800000, 0, 0, 8'h98, 24'h800000, 27'h0000002, 0, 0};
    vt[8] = '{32'h7F800000, 32'h7F7FFFFF, 0, 0, 8'hFF, 24'h800000, 27'h3FFFFFC, 0, 0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #2;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_outputs", 64'(dut_pack), 64'd0);
    tick; tick;
    rst = 1'b0;
    settle;
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_out_valid", 64'(out_valid), 64'd0);

    // Directed vectors, one at a time with no backpressure.
    for (int i = 0; i < 9; i++) begin
      a = vt[i].a; b = vt[i].b; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      settle;
      chk($sformatf("vec%0d_early_valid", i), 64'(out_valid), 64'd0);
      tick;
      settle;
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_data", i), 64'(dut_pack),
          64'({vt[i].sb, vt[i].ss, vt[i].e, vt[i].mb, vt[i].msh, vt[i].sw, vt[i].es}));
      tick;
    end
    tick;

    // Backpressure: third pair must stall until out_ready returns.
    for (int k = 0; k < 3; k++) gen_pair(pa[k], pb[k]);
    out_ready = 1'b0; in_valid = 1'b1;
    a = pa[0]; b = pb[0]; settle;
    chk("bp_ready0", 64'(in_ready), 64'd1);
    tick;
    a = pa[1]; b = pb[1]; settle;
    chk("bp_ready1", 64'(in_ready), 64'd1);
    tick;
    a = pa[2]; b = pb[2]; settle;
    chk("bp_ready2_stall", 64'(in_ready), 64'd0);
    chk("bp_valid", 64'(out_valid), 64'd1);
    prev = dut_pack;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("bp_hold_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_data", 64'({out_valid, dut_pack}), 64'({1'b1, prev}));
    end
    chk("bp_first_result", 64'(prev), 64'(model(pa[0], pb[0])));
    out_ready = 1'b1; settle;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_out%0d_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("bp_out%0d_data", k), 64'(dut_pack), 64'(model(pa[k], pb[k])));
      tick;
      in_valid = 1'b0;
      settle;
    end
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Reset with two pairs in flight.
    out_ready = 1'b0; in_valid = 1'b1;
    gen_pair(pa[0], pb[0]); a = pa[0]; b = pb[0];
    tick;
    gen_pair(pa[1], pb[1]); a = pa[1]; b = pb[1];
    tick;
    in_valid = 1'b0;
    settle;
    chk("rst_pre_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 64'(out_valid), 64'd0);
    chk("rst_async_data", 64'(dut_pack), 64'd0);
    tick;
    gen_pair(pa[2], pb[2]);
    a = pa[2]; b = pb[2]; in_valid = 1'b1; out_ready = 1'b1;
    rst = 1'b0;
    settle;
    chk("rst_release_ready", 64'(in_ready), 64'd1);
    tick;
    in_valid = 1'b0;
    settle;
    chk("rst_no_stale", 64'(out_valid), 64'd0);
    tick;
    chk("rst_lat_valid", 64'(out_valid), 64'd1);
    chk("rst_lat_data", 64'(dut_pack), 64'(model(pa[2], pb[2])));
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      tick;
      if (out_valid) seen++;
    end
    chk("rst_no_extra", 64'(seen), 64'd0);

    // Randomized traffic against the scoreboard.
    hold_prev = 1'b0;
    prev = '0;
    for (int c = 0; c < 600; c++) begin
      if (c < 580) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 9) < 6);
        gen_pair(a, b);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      settle;
      if (hold_prev) chk("rand_hold", 64'({out_valid, dut_pack}), 64'({1'b1, prev}));
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rand_unexpected", 64'd1, 64'd0);
        else chk("rand_emit", 64'(dut_pack), 64'(q.pop_front()));
      end
      if (in_valid && in_ready) q.push_back(model(a, b));
      hold_prev = out_valid && !out_ready;
      prev = dut_pack;
      tick;
    end
    chk("rand_queue_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
